// File: rtl/store_buffer_if.sv
// rtl/store_buffer_if.sv - core store/load, memory drain and status signals of the store buffer
interface store_buffer_if;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic        stall;
  logic [31:0] rd_adr;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_adr;
  logic [31:0] mem_wdata;
  logic        empty;

  modport master (
    output memwrite, dataadr, writedata, rd_adr, mem_ready,
    input  stall, fwd_hit, fwd_data, mem_valid, mem_adr, mem_wdata, empty
  );

  modport slave (
    input  memwrite, dataadr, writedata, rd_adr, mem_ready,
    output stall, fwd_hit, fwd_data, mem_valid, mem_adr, mem_wdata, empty
  );
endinterface

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - in-order store write buffer with youngest-match load forwarding
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  store_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [31:0]   adr_q  [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          enq;
  logic          deq;
  logic          valid;
  logic          hit;
  logic [31:0]   fdata;
  logic [AW-1:0] idx;

  assign valid = (count != '0);
  // full is judged on registered count alone, so a same-cycle drain never admits a store
  assign enq   = bus.memwrite && (count != FULL);
  assign deq   = valid && bus.mem_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (enq) wptr <= wptr + 1'b1;
      if (deq) rptr <= rptr + 1'b1;
      unique case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      adr_q[wptr]  <= bus.dataadr;
      data_q[wptr] <= bus.writedata;
    end
  end

  // walk oldest to youngest so the last word match left standing is the youngest
  always_comb begin
    hit   = 1'b0;
    fdata = '0;
    idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rptr + AW'(i);
      if (((AW+1)'(i) < count) &&
          (((adr_q[idx] ^ bus.rd_adr) & 32'hFFFF_FFFC) == 32'h0)) begin
        hit   = 1'b1;
        fdata = data_q[idx];
      end
    end
  end

  assign bus.stall     = (count == FULL);
  assign bus.empty     = !valid;
  assign bus.mem_valid = valid;
  assign bus.mem_adr   = valid ? adr_q[rptr]  : 32'h0;
  assign bus.mem_wdata = valid ? data_q[rptr] : 32'h0;
  assign bus.fwd_hit   = hit;
  assign bus.fwd_data  = fdata;
endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - directed and randomized checks of store_buffer against a queue model
module tb_store_buffer;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  store_buffer_if sb ();

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sb)
  );

  always #5 clk = ~clk;

  ent_t        q[$];
  logic [31:0] drained[$];
  int          checks   = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive, check outputs against the model, clock, then advance the model.
  task automatic cycle(input logic rst, input logic mw, input logic [31:0] adr,
                       input logic [31:0] wd, input logic [31:0] ra, input logic rdy,
                       output bit accepted);
    logic        eh;
    logic [31:0] fd;
    bit          dq;
    reset        = rst;
    sb.memwrite  = mw;
    sb.dataadr   = adr;
    sb.writedata = wd;
    sb.rd_adr    = ra;
    sb.mem_ready = rdy;
    #1;
    eh = 1'b0;
    fd = 32'h0;
    for (int i = 0; i < q.size(); i++)
      if (q[i].a[31:2] == ra[31:2]) begin
        eh = 1'b1;
        fd = q[i].d;
      end
    chk("stall",     {31'b0, sb.stall},     {31'b0, q.size() == DEPTH});
    chk("empty",     {31'b0, sb.empty},     {31'b0, q.size() == 0});
    chk("mem_valid", {31'b0, sb.mem_valid}, {31'b0, q.size() != 0});
    chk("mem_adr",   sb.mem_adr,   q.size() != 0 ? q[0].a : 32'h0);
    chk("mem_wdata", sb.mem_wdata, q.size() != 0 ? q[0].d : 32'h0);
    chk("fwd_hit",   {31'b0, sb.fwd_hit},   {31'b0, eh});
    chk("fwd_data",  sb.fwd_data,  fd);
    if (!rst && sb.mem_valid && rdy) drained.push_back(sb.mem_adr);
    @(posedge clk);
    #1;
    accepted = 1'b0;
    if (rst) begin
      q.delete();
    end else begin
      accepted = mw && (q.size() < DEPTH);
      dq       = (q.size() != 0) && rdy;
      if (dq) void'(q.pop_front());
      if (accepted) q.push_back({adr, wd});
    end
  endtask

  initial begin
    bit acc;
    bit tog;
    int n;
    int guard;
    reset        = 1'b1;
    sb.memwrite  = 1'b0;
    sb.dataadr   = '0;
    sb.writedata = '0;
    sb.rd_adr    = '0;
    sb.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    q.delete();

    // reset state, then a single store drains the next cycle
    cycle(1, 1, 32'd40, 32'd1, 0, 1, acc);
    cycle(0, 1, 32'd84, 32'd7, 0, 1, acc);
    chk("single_acc", {31'b0, acc}, 32'd1);
    cycle(0, 0, 0, 0, 32'd84, 1, acc);
    cycle(0, 0, 0, 0, 0, 1, acc);
    chk("single_drain_adr", drained.size() == 1 ? drained[0] : 32'hDEAD, 32'd84);

    // fill, reject while full, reject on full+drain, then retry succeeds
    for (int i = 0; i < 4; i++) cycle(0, 1, 32'd80 + 4 * i, i + 1, 0, 0, acc);
    cycle(0, 1, 32'd96, 32'd5, 0, 0, acc);
    chk("full_reject", {31'b0, acc}, 32'd0);
    cycle(0, 1, 32'd96, 32'd5, 0, 1, acc);
    chk("full_drain_reject", {31'b0, acc}, 32'd0);
    cycle(0, 1, 32'd96, 32'd5, 0, 1, acc);
    chk("retry_acc", {31'b0, acc}, 32'd1);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0, 1, acc);

    // forwarding: youngest of two same-word stores wins, other words miss
    drained.delete();
    cycle(0, 1, 32'd84, 32'd7, 0, 0, acc);
    cycle(0, 1, 32'd84, 32'd9, 32'd84, 0, acc);
    cycle(0, 0, 0, 0, 32'd86, 0, acc);
    cycle(0, 0, 0, 0, 32'd88, 0, acc);
    cycle(0, 1, 32'd200, 32'd3, 32'd200, 0, acc);
    cycle(0, 0, 0, 0, 32'd200, 0, acc);

    // reset mid-drain discards everything even with mem_ready high
    cycle(1, 1, 32'd300, 32'd1, 32'd84, 1, acc);
    cycle(0, 0, 0, 0, 32'd84, 1, acc);

    // pointer wrap with toggling mem_ready; every store retried until accepted
    drained.delete();
    n = 0;
    guard = 0;
    tog = 1'b0;
    while (n < 10 && guard < 200) begin
      cycle(0, 1, 32'd1000 + 4 * n, n, 0, tog, acc);
      tog = ~tog;
      guard++;
      if (acc) n++;
    end
    chk("wrap_issue_bound", n, 10);
    for (int i = 0; i < 12; i++) cycle(0, 0, 0, 0, 0, 1, acc);
    chk("wrap_drain_count", drained.size(), 10);
    for (int i = 0; i < 10 && i < drained.size(); i++)
      chk("wrap_order", drained[i], 32'd1000 + 4 * i);

    // randomized traffic over a narrow address window to exercise forwarding
    for (int i = 0; i < 400; i++)
      cycle(($urandom_range(0, 49) == 0), $urandom_range(0, 1),
            32'h100 + $urandom_range(0, 31), $urandom,
            32'h100 + $urandom_range(0, 31), ($urandom_range(0, 2) != 0), acc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
# store_buffer

Store write buffer between the MIPS core's data-memory port (memwrite / dataadr / writedata) and the data memory. Core stores enter a small in-order FIFO and drain to memory through a valid/ready handshake, so a slow memory does not stall every store. Loads from the core are checked against buffered stores and forwarded from the youngest match. The core stalls only when the buffer is full.

## Interface
- DEPTH, 4: number of buffer entries; power of two, ≥ 2.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears buffer on the rising edge where sampled high.
- memwrite  in  1  core store request this cycle.
- dataadr  in  32  store address (byte address, signed view in core; treated as unsigned bits here).
- writedata  in  32  store data.
- stall  out  1  buffer full; core must hold its store and retry.
- rd_adr  in  32  address of the core's current load (combinational lookup).
- fwd_hit  out  1  a buffered store matches rd_adr.
- fwd_data  out  32  data of the youngest matching entry; 0 when fwd_hit=0.
- mem_valid  out  1  head entry offered to memory.
- mem_ready  in  1  memory accepts head entry this cycle.
- mem_adr  out  32  head entry address; 0 when mem_valid=0.
- mem_wdata  out  32  head entry data; 0 when mem_valid=0.
- empty  out  1  no entries held (used by bench/fence logic).

## Operation
- State: DEPTH entries {adr, data}, write pointer, read pointer, count (log2(DEPTH)+1 bits). Pointers wrap modulo DEPTH.
- Enqueue: memwrite=1 and count<DEPTH → write entry at wptr, wptr+1.
- Dequeue: mem_valid=1 and mem_ready=1 → rptr+1.
- Count update: +1 enqueue only, −1 dequeue only, unchanged for both or neither.
- stall = (count==DEPTH), derived from registered count only; no dependence on mem_ready. When full, a store is rejected even if a dequeue occurs that cycle; core retries next cycle.
- memwrite=1 while stall=1: no state change, entry not written.
- mem_valid = (count!=0); mem_adr/mem_wdata = head entry, held stable while mem_valid=1 and mem_ready=0. mem_ready while mem_valid=0 is ignored.
- Addresses stored and presented unchanged; no coalescing — two stores to the same address occupy two entries and drain in order.
- Forwarding: compare rd_adr[31:2] with adr[31:2] of every valid entry (including the head being offered). Multiple matches → youngest (closest to wptr) wins. Purely combinational from registered contents.
- A store enqueued in cycle N is not forwarded in cycle N; visible from cycle N+1.
- empty = (count==0).

## Timing
- Reset values (after reset edge): count=0, pointers=0, stall=0, mem_valid=0, mem_adr=0, mem_wdata=0, fwd_hit=0, fwd_data=0, empty=1. Entry storage need not be cleared.
- Reset mid-drain: all entries discarded, mem_valid low the next cycle regardless of mem_ready; pending stores are lost by design.
- Reset has priority over simultaneous memwrite and mem_ready.
- Store-to-memory latency: store accepted at edge N → mem_valid=1 with that entry from N+1 if buffer was empty.
- With mem_ready held 1, sustained throughput one store per cycle; entry never waits more than count cycles.
- Full case: empty buffer, memwrite every cycle, mem_ready=0 → stall rises after DEPTH accepted stores.

## Test plan
- Reset then single store dataadr=84, writedata=7 with mem_ready=1 → next cycle mem_valid=1, mem_adr=84, mem_wdata=7; following cycle empty=1.
- mem_ready=0, stores to 80,84,88,92 (data 1..4) → stall=1 after 4th; 5th store (96) rejected; raise mem_ready → drains 80,84,88,92 in order, then 96 accepted on retry.
- Full buffer, memwrite and mem_ready both 1 same cycle → store rejected, count 4→3, stall=0 next cycle.
- Stores 84←7 then 84←9 held (mem_ready=0), rd_adr=86 → fwd_hit=1, fwd_data=9; rd_adr=88 → fwd_hit=0, fwd_data=0.
- Pointer wrap: 10 stores with mem_ready toggling every cycle → memory sees all 10 in issue order, no loss or duplication.
- Reset asserted with 3 entries and mem_valid=1 → next cycle mem_valid=0, empty=1, stall=0, fwd_hit=0.
